// File: rtl/cork_tray_loader_pkg.sv
// rtl/cork_tray_loader_pkg.sv - shared cork tray constants, level type and loader state encoding
package cork_tray_loader_pkg;

  localparam int W = 7;

  typedef logic [W-1:0] cork_level_t;

  localparam cork_level_t CAP      = cork_level_t'(99);
  localparam cork_level_t MIN_LVL  = cork_level_t'(5);
  localparam cork_level_t AUTO_AMT = cork_level_t'(20);

  localparam int DEB_CYCLES = 4;
  localparam int ACK_TO     = 15;

  localparam int TMR_W = $clog2(ACK_TO + 1);
  typedef logic [TMR_W-1:0] ack_tmr_t;
  localparam ack_tmr_t ACK_LAST = ack_tmr_t'(ACK_TO - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_REQ  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/cork_tray_loader_if.sv
// rtl/cork_tray_loader_if.sv - tray register load handshake (req/ack with data) plus current level
interface cork_tray_loader_if
  import cork_tray_loader_pkg::*;
();

  logic        load_req;
  cork_level_t load_data;
  logic        load_ack;
  cork_level_t tray_level;

  modport master (
    output load_req,
    output load_data,
    input  load_ack,
    input  tray_level
  );

  modport slave (
    input  load_req,
    input  load_data,
    output load_ack,
    output tray_level
  );

endinterface

// File: rtl/cork_tray_loader_btn_debounce.sv
// rtl/cork_tray_loader_btn_debounce.sv - button sampler, stable-run counter and rising-edge pulse
module cork_btn_debounce #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic          sample_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // count consecutive samples that disagree with the filtered level; flip after DEB of them
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sample_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  // raw sample, filter state and one-cycle press pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sample_q <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sample_q <= btn_i;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cork_tray_loader.sv
// rtl/cork_tray_loader.sv - tray refill loader; optional auto refill under CORK_AUTO_REFILL_EN
module cork_tray_loader
  import cork_tray_loader_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                enable,
  input  logic                btn_add,
  input  logic                btn_load,
  cork_tray_loader_if.master  ld,
  output cork_level_t         pending,
  output logic                busy,
  output logic                low_tray,
  output logic                ovf_err,
  output logic                to_err
);

  logic add_pulse, load_pulse;

  cork_btn_debounce #(.DEB(DEB_CYCLES)) u_deb_add (
    .clk     (clk),
    .clr     (clr),
    .btn_i   (btn_add),
    .pulse_o (add_pulse)
  );

  cork_btn_debounce #(.DEB(DEB_CYCLES)) u_deb_load (
    .clk     (clk),
    .clr     (clr),
    .btn_i   (btn_load),
    .pulse_o (load_pulse)
  );

  loader_state_t state_q, state_d;
  cork_level_t   pending_q, pending_d;
  cork_level_t   xfer_q, xfer_d;
  cork_level_t   data_q, data_d;
  logic          req_q, req_d;
  ack_tmr_t      tmr_q, tmr_d;
  logic          auto_q, auto_d;
  logic          low_q, low_d;
  logic          ovf_q, ovf_d;
  logic          to_q, to_d;

  cork_level_t   amt;
  cork_level_t   base;
  logic [W:0]    sum;

  // next-state, clamp arithmetic and pending bookkeeping
  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    data_d  = data_q;
    req_d   = req_q;
    tmr_d   = tmr_q;
    auto_d  = auto_q;
    ovf_d   = 1'b0;
    to_d    = 1'b0;
    amt     = '0;
    sum     = '0;
    base    = pending_q;
    low_d   = (ld.tray_level < MIN_LVL);

    case (state_q)
      ST_IDLE: begin
        if (load_pulse && enable && (pending_q != '0)) begin
          state_d = ST_CALC;
          auto_d  = 1'b0;
        end
`ifdef CORK_AUTO_REFILL_EN
        else if (enable && low_q) begin
          state_d = ST_CALC;
          auto_d  = 1'b1;
        end
`endif
      end
      ST_CALC: begin
        amt = auto_q ? AUTO_AMT : pending_q;
        sum = {1'b0, ld.tray_level} + {1'b0, amt};
        if (sum > {1'b0, CAP}) begin
          data_d = CAP;
          xfer_d = (ld.tray_level >= CAP) ? '0 : (CAP - ld.tray_level);
          ovf_d  = 1'b1;
        end else begin
          data_d = sum[W-1:0];
          xfer_d = amt;
        end
        // auto refills never draw on the operator's pending count
        if (auto_q) begin
          xfer_d = '0;
        end
        req_d   = 1'b1;
        tmr_d   = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ld.load_ack) begin
          base    = pending_q - xfer_q;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_q == ACK_LAST) begin
          to_d    = 1'b1;
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    pending_d = (add_pulse && (base < CAP)) ? (base + 1'b1) : base;
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      xfer_q    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      tmr_q     <= '0;
      auto_q    <= 1'b0;
      low_q     <= 1'b0;
      ovf_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      xfer_q    <= xfer_d;
      data_q    <= data_d;
      req_q     <= req_d;
      tmr_q     <= tmr_d;
      auto_q    <= auto_d;
      low_q     <= low_d;
      ovf_q     <= ovf_d;
      to_q      <= to_d;
    end
  end

  assign ld.load_req  = req_q;
  assign ld.load_data = data_q;
  assign pending      = pending_q;
  assign busy         = (state_q != ST_IDLE);
  assign low_tray     = low_q;
  assign ovf_err      = ovf_q;
  assign to_err       = to_q;

endmodule

// File: tb/tb_cork_tray_loader.sv
// tb/tb_cork_tray_loader.sv - randomized bench with a transaction-level tray refill model
module tb_cork_tray_loader;

  localparam int T_CAP    = 99;
  localparam int T_DEB    = 4;
  localparam int T_ACK_TO = 15;
  localparam int T_AUTO   = 20;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable;
  logic       btn_add;
  logic       btn_load;
  logic [6:0] pending;
  logic       busy, low_tray, ovf_err, to_err;

  cork_tray_loader_if ld_if ();

  cork_tray_loader dut (
    .clk      (clk),
    .clr      (clr),
    .enable   (enable),
    .btn_add  (btn_add),
    .btn_load (btn_load),
    .ld       (ld_if.master),
    .pending  (pending),
    .busy     (busy),
    .low_tray (low_tray),
    .ovf_err  (ovf_err),
    .to_err   (to_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int m_pend   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_add();
    btn_add = 1'b1;
    idle(T_DEB + 2);
    btn_add = 1'b0;
    idle(T_DEB + 2);
    m_pend = (m_pend + 1 > T_CAP) ? T_CAP : m_pend + 1;
  endtask

  // mode 0: ack after ack_dly cycles; mode 1: never ack; mode 2: clr while requesting
  task automatic do_commit(input int tray, input int mode, input int ack_dly, input bit add_on_ack);
    int  n;
    int  cnt;
    int  sum;
    int  exp_data;
    int  xfer;
    bit  seen;
    bit  exp_req;
    ld_if.tray_level = tray[6:0];
    sum      = tray + m_pend;
    exp_data = (sum > T_CAP) ? T_CAP : sum;
    xfer     = exp_data - tray;
    exp_req  = enable && (m_pend > 0);
    btn_load = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 12 && !seen) begin
      @(negedge clk);
      n++;
      if (ld_if.load_req) seen = 1'b1;
    end
    btn_load = 1'b0;
    if (!exp_req) begin
      check_val("ignored_commit_req", int'(seen), 0);
      check_val("ignored_commit_busy", int'(busy), 0);
      idle(T_DEB + 2);
      return;
    end
    check_val("req_latency", n, T_DEB + 3);
    if (!seen) begin
      idle(T_DEB + 2);
      return;
    end
    check_val("load_data", int'(ld_if.load_data), exp_data);
    check_val("ovf_err", int'(ovf_err), int'(sum > T_CAP));
    check_val("busy_in_req", int'(busy), 1);
    if (mode == 0) begin
      if (add_on_ack) btn_add = 1'b1;
      idle(ack_dly);
      check_val("data_hold", int'(ld_if.load_data), exp_data);
      ld_if.load_ack = 1'b1;
      @(negedge clk);
      ld_if.load_ack = 1'b0;
      m_pend = m_pend - xfer + (add_on_ack ? 1 : 0);
      check_val("pending_after_ack", int'(pending), m_pend);
      check_val("req_after_ack", int'(ld_if.load_req), 0);
      check_val("busy_after_ack", int'(busy), 0);
      btn_add = 1'b0;
    end else if (mode == 1) begin
      cnt = 1;
      while (ld_if.load_req && cnt < 40) begin
        @(negedge clk);
        if (ld_if.load_req) cnt++;
      end
      check_val("req_cycles_before_timeout", cnt, T_ACK_TO);
      check_val("to_err", int'(to_err), 1);
      check_val("pending_after_timeout", int'(pending), m_pend);
    end else begin
      #2 clr = 1'b1;
      #1;
      check_val("req_on_clr", int'(ld_if.load_req), 0);
      check_val("pending_on_clr", int'(pending), 0);
      check_val("busy_on_clr", int'(busy), 0);
      @(negedge clk);
      clr = 1'b0;
      m_pend = 0;
    end
    idle(T_DEB + 2);
  endtask

  initial begin
    int run;
    int na;
    bit seen;
    clr              = 1'b1;
    enable           = 1'b1;
    btn_add          = 1'b0;
    btn_load         = 1'b0;
    ld_if.load_ack   = 1'b0;
    ld_if.tray_level = 7'd50;
    idle(3);
    check_val("rst_pending", int'(pending), 0);
    check_val("rst_load_req", int'(ld_if.load_req), 0);
    check_val("rst_load_data", int'(ld_if.load_data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_low_tray", int'(low_tray), 0);
    check_val("rst_ovf_err", int'(ovf_err), 0);
    check_val("rst_to_err", int'(to_err), 0);
    clr = 1'b0;
    idle(2);

    do_commit(50, 0, 2, 1'b0);

    repeat (7) press_add();
    check_val("pending_7_adds", int'(pending), 7);
    do_commit(10, 0, 2, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run = $urandom_range(1, T_DEB - 1);
      btn_add = 1'b1;
      idle(run);
      run = $urandom_range(1, T_DEB - 1);
      btn_add = 1'b0;
      idle(run);
    end
    press_add();
    check_val("bounce_single_add", int'(pending), m_pend);

    press_add();
    enable = 1'b0;
    do_commit(50, 0, 2, 1'b0);
    enable = 1'b1;

    while (m_pend < 10) press_add();
    check_val("pending_10", int'(pending), 10);
    do_commit(95, 0, 3, 1'b0);
    check_val("residual_after_clamp", int'(pending), 6);
    do_commit(99, 0, 1, 1'b0);
    check_val("pending_tray_full", int'(pending), 6);

    do_commit(50, 1, 0, 1'b0);

    do_commit(96, 0, 4, 1'b0);
    check_val("pending_3", int'(pending), 3);
    do_commit(20, 0, 5, 1'b1);
    check_val("pending_add_on_ack", int'(pending), 1);

    ld_if.load_ack = 1'b1;
    @(negedge clk);
    ld_if.load_ack = 1'b0;
    idle(2);
    check_val("stray_ack_ignored", int'(pending), m_pend);
    check_val("stray_ack_busy", int'(busy), 0);

    do_commit(20, 2, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      na = $urandom_range(0, 6);
      repeat (na) press_add();
      check_val("rand_pending", int'(pending), m_pend);
      do_commit($urandom_range(5, T_CAP), 0, $urandom_range(0, T_ACK_TO - 2), 1'b0);
    end

    ld_if.tray_level = 7'd4;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ld_if.load_req) seen = 1'b1;
    end
    check_val("low_tray_flag", int'(low_tray), 1);
`ifdef CORK_AUTO_REFILL_EN
    check_val("auto_req", int'(seen), 1);
    check_val("auto_load_data", int'(ld_if.load_data), 4 + T_AUTO);
    check_val("auto_pending_before_ack", int'(pending), m_pend);
    ld_if.tray_level = 7'd50;
    idle(1);
    ld_if.load_ack = 1'b1;
    @(negedge clk);
    ld_if.load_ack = 1'b0;
    check_val("auto_pending_after_ack", int'(pending), m_pend);
    check_val("auto_busy_after_ack", int'(busy), 0);
`else
    check_val("no_auto_req", int'(seen), 0);
    check_val("no_auto_busy", int'(busy), 0);
`endif
    ld_if.tray_level = 7'd50;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
